// File: rtl/ppu_pkg.sv
// Shared PPU definitions: register indices, palette page select and the
// pending palette request record.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam logic [5:0] PAL_BASE = 6'h3F;

  typedef struct packed {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
  } pal_req_t;

endpackage

// File: rtl/ppu_vaddr_reg.sv
// PPU VRAM address register v with the $2006 write toggle and the
// post-$2007 auto-increment.
module ppu_vaddr_reg
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cpu_reg_sel_i,
  input  logic        cpu_reg_wr_i,
  input  logic        cpu_reg_rd_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        addr_inc32_i,
  output logic [13:0] v_o,
  output logic        data_acc_o
);

  logic [13:0] v_q, v_d;
  logic        w_q, w_d;
  logic        addr_wr;
  logic        status_rd;
  logic        data_acc;

  always_comb begin
    v_d       = v_q;
    w_d       = w_q;
    addr_wr   = cpu_reg_wr_i && (cpu_reg_sel_i == REG_ADDR);
    status_rd = cpu_reg_rd_i && (cpu_reg_sel_i == REG_STATUS);
    data_acc  = (cpu_reg_wr_i || cpu_reg_rd_i) && (cpu_reg_sel_i == REG_DATA);

    if (addr_wr) begin
      if (!w_q) begin
        v_d = {cpu_data_i[5:0], v_q[7:0]};
        w_d = 1'b1;
      end else begin
        v_d = {v_q[13:8], cpu_data_i};
        w_d = 1'b0;
      end
    end

    // 14-bit addition wraps 3FFF -> 0000 naturally.
    if (data_acc) begin
      v_d = v_q + (addr_inc32_i ? 14'd32 : 14'd1);
    end

    // Status read wins over the toggle update of a coincident $2006 write.
    if (status_rd) begin
      w_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      w_q <= 1'b0;
    end else begin
      v_q <= v_d;
      w_q <= w_d;
    end
  end

  assign v_o        = v_q;
  assign data_acc_o = data_acc;

endmodule

// File: rtl/ppu_palette_access_ctrl.sv
// Palette memory initiator: arbitrates pixel colour lookups against CPU
// $2007 palette accesses and forwards non-palette $2007 traffic to VRAM.
module ppu_palette_access_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned PIX_LAT  = 2,
  parameter logic [5:0]  PAL_BASE = ppu_pkg::PAL_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cpu_reg_sel,
  input  logic        cpu_reg_wr,
  input  logic        cpu_reg_rd,
  input  logic [7:0]  cpu_data_in,
  input  logic        addr_inc32,
  input  logic        pix_valid,
  input  logic [4:0]  pix_pal_idx,
  input  logic [7:0]  pal_color_in,
  output logic [4:0]  pal_addr,
  output logic [7:0]  pal_data_out,
  output logic        palette_mem_rw,
  output logic        palette_mem_en,
  output logic [5:0]  color_out,
  output logic        color_valid,
  output logic [7:0]  cpu_pal_rd_data,
  output logic        cpu_pal_rd_valid,
  output logic [13:0] vram_addr,
  output logic        vram_req,
  output logic        vram_req_wr,
  output logic [7:0]  vram_wdata,
  output logic        pend_drop
);

  logic [13:0] v;
  logic        data_acc;
  logic        is_pal;
  logic        pal_acc;
  logic        issue;

  ppu_vaddr_reg u_vaddr (
    .clk           (clk),
    .rst           (rst),
    .cpu_reg_sel_i (cpu_reg_sel),
    .cpu_reg_wr_i  (cpu_reg_wr),
    .cpu_reg_rd_i  (cpu_reg_rd),
    .cpu_data_i    (cpu_data_in),
    .addr_inc32_i  (addr_inc32),
    .v_o           (v),
    .data_acc_o    (data_acc)
  );

  pal_req_t   pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic       drop_q, drop_d;
  logic       en_q, en_d;
  logic       rw_q, rw_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       pix_rd_q, pix_rd_d;
  logic       cpu_rd_q, cpu_rd_d;

  logic [5:0]  color_q;
  logic        color_valid_q;
  logic [7:0]  cpu_rd_data_q;
  logic        cpu_rd_valid_q;
  logic [13:0] vram_addr_q;
  logic        vram_req_q;
  logic        vram_req_wr_q;
  logic [7:0]  vram_wdata_q;

  always_comb begin
    is_pal  = (v[13:8] == PAL_BASE);
    pal_acc = data_acc && is_pal;
    issue   = pend_valid_q && !pix_valid;

    // An entry issuing this cycle frees the slot for a same-cycle arrival.
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q && !issue;
    drop_d       = drop_q;
    if (pal_acc) begin
      if (!pend_valid_d) begin
        pend_d.wr    = cpu_reg_wr;
        pend_d.addr  = v[4:0];
        pend_d.data  = cpu_data_in;
        pend_valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end

    en_d     = 1'b0;
    rw_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pix_rd_d = 1'b0;
    cpu_rd_d = 1'b0;
    if (pix_valid) begin
      en_d     = 1'b1;
      addr_d   = pix_pal_idx;
      pix_rd_d = 1'b1;
    end else if (pend_valid_q) begin
      en_d     = 1'b1;
      rw_d     = pend_q.wr;
      addr_d   = pend_q.addr;
      wdata_d  = pend_q.data;
      cpu_rd_d = !pend_q.wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      drop_q         <= 1'b0;
      en_q           <= 1'b0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      pix_rd_q       <= 1'b0;
      cpu_rd_q       <= 1'b0;
      color_q        <= '0;
      color_valid_q  <= 1'b0;
      cpu_rd_data_q  <= '0;
      cpu_rd_valid_q <= 1'b0;
      vram_addr_q    <= '0;
      vram_req_q     <= 1'b0;
      vram_req_wr_q  <= 1'b0;
      vram_wdata_q   <= '0;
    end else begin
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      drop_q         <= drop_d;
      en_q           <= en_d;
      rw_q           <= rw_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      pix_rd_q       <= pix_rd_d;
      cpu_rd_q       <= cpu_rd_d;
      // Memory data is combinational on the issued address; capture it here.
      color_valid_q  <= pix_rd_q;
      if (pix_rd_q) color_q <= pal_color_in[5:0];
      cpu_rd_valid_q <= cpu_rd_q;
      if (cpu_rd_q) cpu_rd_data_q <= {2'b00, pal_color_in[5:0]};
      // Tracking v one cycle late shows the pre-increment address with vram_req.
      vram_addr_q    <= v;
      vram_req_q     <= data_acc && !is_pal;
      if (data_acc && !is_pal) begin
        vram_req_wr_q <= cpu_reg_wr;
        vram_wdata_q  <= cpu_data_in;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pal_color_in[7:6], PIX_LAT[0]};

  assign pal_addr         = addr_q;
  assign pal_data_out     = wdata_q;
  assign palette_mem_rw   = rw_q;
  assign palette_mem_en   = en_q;
  assign color_out        = color_q;
  assign color_valid      = color_valid_q;
  assign cpu_pal_rd_data  = cpu_rd_data_q;
  assign cpu_pal_rd_valid = cpu_rd_valid_q;
  assign vram_addr        = vram_addr_q;
  assign vram_req         = vram_req_q;
  assign vram_req_wr      = vram_req_wr_q;
  assign vram_wdata       = vram_wdata_q;
  assign pend_drop        = drop_q;

endmodule

// File: doc/ppu_palette_access_ctrl.md
Name: ppu_palette_access_ctrl

Overview:
Initiator side of the PPU palette memory port. It owns the PPU VRAM address register (v) and the $2006/$2007 write toggle. It arbitrates between the pixel pipeline's colour lookups and CPU $2007 palette reads and writes, and drives pal_addr, palette_data_in, palette_mem_rw and palette_mem_en. It returns the 6-bit NES colour to the video pipeline and palette read data to the CPU; accesses outside the palette range are forwarded as VRAM requests.

Parameters:
PIX_LAT, 2, cycles from pix_valid to color_valid (fixed; a parameter for documentation and bench only)
PAL_BASE, 6'h3F, v[13:8] value that selects palette space

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_reg_sel  in  3  PPU register index ($2000+sel)
cpu_reg_wr  in  1  one-cycle CPU register write strobe
cpu_reg_rd  in  1  one-cycle CPU register read strobe
cpu_data_in  in  8  CPU write data
addr_inc32  in  1  PPUCTRL bit 2: increment v by 32 instead of 1
pix_valid  in  1  pixel pipeline requests a lookup this cycle
pix_pal_idx  in  5  palette index from the pixel mux
pal_color_in  in  8  color_out from palette memory (combinational)
pal_addr  out  5  palette memory address
pal_data_out  out  8  palette write data
palette_mem_rw  out  1  1 = write, 0 = read
palette_mem_en  out  1  palette memory enable
color_out  out  6  NES colour index to the video pipeline
color_valid  out  1  color_out is valid
cpu_pal_rd_data  out  8  palette read data, bits 7:6 forced to 0
cpu_pal_rd_valid  out  1  one-cycle pulse with cpu_pal_rd_data
vram_addr  out  14  current v register
vram_req  out  1  one-cycle non-palette $2007 access request
vram_req_wr  out  1  qualifies vram_req: 1 = write
vram_wdata  out  8  write data for vram_req
pend_drop  out  1  sticky: a CPU palette access was dropped

Behaviour:
- Reset: all outputs 0; v=0; toggle w=0; pending buffer empty; pend_drop=0. Reset mid-access aborts all in-flight operations; there are no partial writes afterwards.
- $2006 write (sel=6):
  - w=0: v[13:8] <= cpu_data_in[5:0], w <= 1.
  - w=1: v[7:0] <= cpu_data_in, w <= 0.
  - A $2002 read (sel=2, cpu_reg_rd) clears w. If it coincides with a $2006 write, the write uses the old w and w ends at 0.
- $2007 access (sel=7):
  - If v[13:8]==PAL_BASE, load the one-deep pending buffer {wr, addr=v[4:0], data}.
  - Otherwise pulse vram_req the next cycle with vram_addr=v (pre-increment), vram_req_wr, and vram_wdata.
  - In both cases v <= v+1, or v+32 if addr_inc32, modulo 2^14 (3FFF+1 -> 0000).
- Pending full when a new palette $2007 arrives: the new access is dropped, v still increments, and pend_drop is set until rst.
- Arbitration, evaluated each cycle on registered outputs:
  - pix_valid has priority. Next cycle: en=1, rw=0, pal_addr=pix_pal_idx.
  - Else, if pending is non-empty, issue it next cycle (en=1, rw=pending.wr, pal_addr, pal_data_out) and clear pending.
  - Else en=0, rw=0.
  - Consequence: a CPU access is deferred until a cycle with pix_valid=0; it is never lost.
- Pixel read latency: pix_valid at cycle N -> memory access at N+1; pal_color_in[5:0] is registered -> color_out and color_valid at N+2. color_valid=0 on cycles with no lookup; color_out holds its last value.
- CPU palette read: issued from pending at cycle M -> cpu_pal_rd_valid and cpu_pal_rd_data={2'b00, pal_color_in[5:0]} at M+1.
- Pending load and issue in the same cycle: a pending entry issuing this cycle frees the slot, so a simultaneous new palette $2007 is accepted with no drop.
- Address mirroring ($3F10/14/18/1C) is not performed here; the raw v[4:0] is passed to memory.

Decomposition:
- Shared package ppu_pkg:
  - PPU register index constants (REG_CTRL=0, REG_STATUS=2, REG_ADDR=6, REG_DATA=7)
  - PAL_BASE
  - typedef pal_req_t {wr, addr[4:0], data[7:0]}
- One sub-module, ppu_vaddr_reg: v register, w toggle and increment logic.

Test Plan:
- Reset, then $2006<=3F, $2006<=05, $2007<=0x16, pix_valid=0 -> next cycle en=1, rw=1, pal_addr=05, pal_data_out=16; v=3F06.
- pix_valid held high 4 cycles, with a palette $2007 write arriving in the 2nd cycle -> write issued on the cycle after pix_valid falls; 4 color_valid pulses, each 2 cycles after its request; no drop.
- pix_pal_idx=0x0B at N with pal_color_in=0xE7 -> color_out=0x27 and color_valid at N+2.
- v=3F1F, addr_inc32=0, palette $2007 read with memory returning 0x30 -> cpu_pal_rd_data=0x30, pulsed once; v becomes 3F20.
- v=3FFF with a $2007 write: the access is a palette access; v wraps to 0000. Then v=2000 with a $2007 write of 0xAA -> vram_req=1, vram_req_wr=1, vram_addr=2000, vram_wdata=AA.
- pix_valid held high and two palette $2007 writes back-to-back -> second write dropped and pend_drop=1; first $2006 write, $2002 read, $2006 write -> the last write lands in the high byte (w was cleared).
